// File: rtl/dev_bus_arbiter_pkg.sv
// Shared definitions for the two-master device bus arbiter: FSM encodings,
// arbitration reset value and the device address windows behind the bridge.
package dev_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Master 0 wins the first tie because last starts pointing at master 1.
   localparam logic LAST_RESET = 1'b1;

   localparam logic [31:0] DEV0_BASE = 32'h0000_7F00;
   localparam logic [31:0] DEV0_TOP  = 32'h0000_7F0B;
   localparam logic [31:0] DEV1_BASE = 32'h0000_7F10;
   localparam logic [31:0] DEV1_TOP  = 32'h0000_7F1B;

   function automatic logic in_dev_window(input logic [31:0] addr);
      return ((addr >= DEV0_BASE) && (addr <= DEV0_TOP)) ||
             ((addr >= DEV1_BASE) && (addr <= DEV1_TOP));
   endfunction

endpackage

// File: rtl/dev_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the master that did not
// win last time is chosen.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_id
);

   always_comb begin
      gnt_valid = |req;
      gnt_id    = 1'b0;
      if (req == 2'b11) begin
         gnt_id = ~last;
      end else if (req[1]) begin
         gnt_id = 1'b1;
      end
   end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Shares the device bridge between two masters; each access is a registered
// IDLE -> XFER -> RESP sequence with round-robin grant on ties.
module dev_bus_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic          m0_we,
   input  logic [DW-1:0] m0_wd,
   output logic          m0_done,
   output logic [DW-1:0] m0_rd,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic          m1_we,
   input  logic [DW-1:0] m1_wd,
   output logic          m1_done,
   output logic [DW-1:0] m1_rd,
   output logic [AW-1:0] pr_addr,
   output logic          pr_we,
   output logic [DW-1:0] pr_wd,
   input  logic [DW-1:0] pr_rd
);
   import dev_bus_arbiter_pkg::*;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic          owner_q, owner_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [DW-1:0] wd_q, wd_d;
   logic          m0_done_q, m0_done_d;
   logic          m1_done_q, m1_done_d;
   logic [DW-1:0] m0_rd_q, m0_rd_d;
   logic [DW-1:0] m1_rd_q, m1_rd_d;

   logic          gnt_valid;
   logic          gnt_id;

   rr_arb2 u_rr_arb2 (
      .req       ({m1_req, m0_req}),
      .last      (last_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wd_d      = wd_q;
      m0_done_d = 1'b0;
      m1_done_d = 1'b0;
      m0_rd_d   = m0_rd_q;
      m1_rd_d   = m1_rd_q;

      case (state_q)
         S_IDLE: begin
            if (gnt_valid) begin
               state_d = S_XFER;
               owner_d = gnt_id;
               last_d  = gnt_id;
               if (gnt_id) begin
                  addr_d = m1_addr;
                  we_d   = m1_we;
                  wd_d   = m1_wd;
               end else begin
                  addr_d = m0_addr;
                  we_d   = m0_we;
                  wd_d   = m0_wd;
               end
            end
         end

         // Bridge read data is captured on writes too; masters simply ignore it.
         S_XFER: begin
            state_d = S_RESP;
            addr_d  = '0;
            we_d    = 1'b0;
            wd_d    = '0;
            if (owner_q) begin
               m1_rd_d   = pr_rd;
               m1_done_d = 1'b1;
            end else begin
               m0_rd_d   = pr_rd;
               m0_done_d = 1'b1;
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            addr_d  = '0;
            we_d    = 1'b0;
            wd_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         last_q    <= LAST_RESET;
         owner_q   <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wd_q      <= '0;
         m0_done_q <= 1'b0;
         m1_done_q <= 1'b0;
         m0_rd_q   <= '0;
         m1_rd_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wd_q      <= wd_d;
         m0_done_q <= m0_done_d;
         m1_done_q <= m1_done_d;
         m0_rd_q   <= m0_rd_d;
         m1_rd_q   <= m1_rd_d;
      end
   end

   assign pr_addr = addr_q;
   assign pr_we   = we_q;
   assign pr_wd   = wd_q;
   assign m0_done = m0_done_q;
   assign m1_done = m1_done_q;
   assign m0_rd   = m0_rd_q;
   assign m1_rd   = m1_rd_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter: a table of single transactions
// followed by hand-written back-to-back, late-request and reset sequences.
module tb_dev_bus_arbiter;
   import dev_bus_arbiter_pkg::*;

   logic        clk;
   logic        reset;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m1_addr;
   logic        m0_we, m1_we;
   logic [31:0] m0_wd, m1_wd;
   logic        m0_done, m1_done;
   logic [31:0] m0_rd, m1_rd;
   logic [31:0] pr_addr;
   logic        pr_we;
   logic [31:0] pr_wd;
   logic [31:0] pr_rd;

   int          cmpCount;
   int          failCount;
   int          weCount;
   logic [31:0] expRd0, expRd1;

   typedef struct {
      logic        m0Req;
      logic [31:0] m0Addr;
      logic        m0We;
      logic [31:0] m0Wd;
      logic        m1Req;
      logic [31:0] m1Addr;
      logic        m1We;
      logic [31:0] m1Wd;
      logic        expId;
      logic [31:0] expAddr;
      logic        expWe;
      logic [31:0] expWd;
      logic [31:0] expRd;
   } vec_t;

   vec_t vecs [9];

   dev_bus_arbiter #(.AW(32), .DW(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .m0_req  (m0_req),
      .m0_addr (m0_addr),
      .m0_we   (m0_we),
      .m0_wd   (m0_wd),
      .m0_done (m0_done),
      .m0_rd   (m0_rd),
      .m1_req  (m1_req),
      .m1_addr (m1_addr),
      .m1_we   (m1_we),
      .m1_wd   (m1_wd),
      .m1_done (m1_done),
      .m1_rd   (m1_rd),
      .pr_addr (pr_addr),
      .pr_we   (pr_we),
      .pr_wd   (pr_wd),
      .pr_rd   (pr_rd)
   );

   // Bridge model: one magic register, mapped windows echo the address, rest reads 0.
   function automatic logic [31:0] bridgeModel(input logic [31:0] addr);
      if (addr == 32'h0000_7F14) return 32'hDEAD_BEEF;
      if (in_dev_window(addr)) return {16'hA5A5, addr[15:0]};
      return 32'h0;
   endfunction

   assign pr_rd = bridgeModel(pr_addr);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts the cycles pr_we is high so write pulses can be checked for width.
   always @(negedge clk) begin
      if (pr_we) weCount++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      cmpCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic clearInputs();
      m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_wd = '0;
      m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_wd = '0;
   endtask

   task automatic resetDut();
      clearInputs();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Called on an IDLE-cycle negedge; returns on the following IDLE-cycle negedge.
   task automatic applyStimulus(input vec_t v, input int idx);
      int weBefore;
      weBefore = weCount;
      m0_req = v.m0Req; m0_addr = v.m0Addr; m0_we = v.m0We; m0_wd = v.m0Wd;
      m1_req = v.m1Req; m1_addr = v.m1Addr; m1_we = v.m1We; m1_wd = v.m1Wd;
      @(negedge clk);
      checkOutput($sformatf("v%0d xfer pr_addr", idx), pr_addr, v.expAddr);
      checkOutput($sformatf("v%0d xfer pr_we", idx), {31'b0, pr_we}, {31'b0, v.expWe});
      checkOutput($sformatf("v%0d xfer pr_wd", idx), pr_wd, v.expWd);
      checkOutput($sformatf("v%0d xfer dones", idx), {30'b0, m1_done, m0_done}, 32'h0);
      @(negedge clk);
      if (v.expId) expRd1 = v.expRd;
      else         expRd0 = v.expRd;
      checkOutput($sformatf("v%0d resp dones", idx), {30'b0, m1_done, m0_done},
                  v.expId ? 32'h2 : 32'h1);
      checkOutput($sformatf("v%0d resp rd", idx), v.expId ? m1_rd : m0_rd, v.expRd);
      clearInputs();
      @(negedge clk);
      checkOutput($sformatf("v%0d idle bus", idx), pr_addr | pr_wd | {31'b0, pr_we}, 32'h0);
      checkOutput($sformatf("v%0d idle dones", idx), {30'b0, m1_done, m0_done}, 32'h0);
      checkOutput($sformatf("v%0d hold m0_rd", idx), m0_rd, expRd0);
      checkOutput($sformatf("v%0d hold m1_rd", idx), m1_rd, expRd1);
      checkOutput($sformatf("v%0d we cycles", idx), weCount - weBefore, {31'b0, v.expWe});
   endtask

   initial begin
      cmpCount  = 0;
      failCount = 0;
      weCount   = 0;
      expRd0    = '0;
      expRd1    = '0;
      clearInputs();
      reset = 1'b1;

      vecs[0] = '{1'b1, 32'h7F04, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0, 32'h0,
                  1'b0, 32'h7F04, 1'b1, 32'h12345678, 32'hA5A57F04};
      vecs[1] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h7F14, 1'b0, 32'h11110000,
                  1'b1, 32'h7F14, 1'b0, 32'h11110000, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 32'h7F08, 1'b0, 32'h0, 1'b1, 32'h7F18, 1'b1, 32'hCAFEF00D,
                  1'b0, 32'h7F08, 1'b0, 32'h0, 32'hA5A57F08};
      vecs[3] = '{1'b1, 32'h7F08, 1'b0, 32'h0, 1'b1, 32'h7F18, 1'b1, 32'hCAFEF00D,
                  1'b1, 32'h7F18, 1'b1, 32'hCAFEF00D, 32'hA5A57F18};
      vecs[4] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h3000, 1'b0, 32'h0,
                  1'b1, 32'h3000, 1'b0, 32'h0, 32'h0};
      vecs[5] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h7F1B, 1'b0, 32'h5,
                  1'b1, 32'h7F1B, 1'b0, 32'h5, 32'hA5A57F1B};
      vecs[6] = '{1'b1, 32'h7F00, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h7F10, 1'b0, 32'h0,
                  1'b0, 32'h7F00, 1'b1, 32'hFFFFFFFF, 32'hA5A57F00};
      vecs[7] = '{1'b1, 32'h7F0B, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                  1'b0, 32'h7F0B, 1'b0, 32'h0, 32'hA5A57F0B};
      vecs[8] = '{1'b1, 32'h7F0C, 1'b0, 32'h0, 1'b1, 32'h7F10, 1'b1, 32'h0BADF00D,
                  1'b1, 32'h7F10, 1'b1, 32'h0BADF00D, 32'hA5A57F10};

      #3;
      checkOutput("reset pr_addr", pr_addr, 32'h0);
      checkOutput("reset pr_we", {31'b0, pr_we}, 32'h0);
      checkOutput("reset pr_wd", pr_wd, 32'h0);
      checkOutput("reset dones", {30'b0, m1_done, m0_done}, 32'h0);
      checkOutput("reset m0_rd", m0_rd, 32'h0);
      checkOutput("reset m1_rd", m1_rd, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] table vectors");
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Both masters held from reset: grants alternate and dones are 3 cycles apart.
      $display("[TB] back-to-back sequence");
      resetDut();
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 32'h7F00; m0_we = 1'b0;
      m1_req = 1'b1; m1_addr = 32'h7F10; m1_we = 1'b0;
      for (int cyc = 1; cyc <= 11; cyc++) begin
         @(negedge clk);
         checkOutput($sformatf("b2b c%0d m0_done", cyc), {31'b0, m0_done},
                     (cyc == 2 || cyc == 8) ? 32'h1 : 32'h0);
         checkOutput($sformatf("b2b c%0d m1_done", cyc), {31'b0, m1_done},
                     (cyc == 5 || cyc == 11) ? 32'h1 : 32'h0);
         if (cyc == 2) checkOutput("b2b m0_rd", m0_rd, 32'hA5A57F00);
         if (cyc == 5) checkOutput("b2b m1_rd", m1_rd, 32'hA5A57F10);
         if (cyc == 11) clearInputs();
      end

      // M1 raises its request while M0's transfer is on the bus.
      $display("[TB] late request sequence");
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 32'h7F04; m0_we = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         checkOutput($sformatf("late c%0d m0_done", cyc), {31'b0, m0_done},
                     (cyc == 2 || cyc == 8) ? 32'h1 : 32'h0);
         checkOutput($sformatf("late c%0d m1_done", cyc), {31'b0, m1_done},
                     (cyc == 5) ? 32'h1 : 32'h0);
         if (cyc == 1) begin
            m1_req = 1'b1; m1_addr = 32'h7F14; m1_we = 1'b0;
         end
         if (cyc == 4) checkOutput("late m1 pr_addr", pr_addr, 32'h7F14);
         if (cyc == 5) begin
            checkOutput("late m1_rd", m1_rd, 32'hDEADBEEF);
            m1_req = 1'b0;
         end
         if (cyc == 7) checkOutput("late m0 pr_addr", pr_addr, 32'h7F04);
         if (cyc == 8) m0_req = 1'b0;
      end

      // Reset lands in the middle of a write transfer; the request survives it.
      $display("[TB] reset during transfer");
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 32'h7F04; m0_we = 1'b1; m0_wd = 32'hA0A0A0A0;
      @(negedge clk);
      checkOutput("rst xfer pr_we", {31'b0, pr_we}, 32'h1);
      #1 reset = 1'b1;
      #1;
      checkOutput("rst async pr_we", {31'b0, pr_we}, 32'h0);
      checkOutput("rst async pr_addr", pr_addr, 32'h0);
      checkOutput("rst async pr_wd", pr_wd, 32'h0);
      checkOutput("rst async m1_rd", m1_rd, 32'h0);
      checkOutput("rst async m0_rd", m0_rd, 32'h0);
      @(negedge clk);
      checkOutput("rst held dones", {30'b0, m1_done, m0_done}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst retry pr_we", {31'b0, pr_we}, 32'h1);
      checkOutput("rst retry pr_addr", pr_addr, 32'h7F04);
      checkOutput("rst retry pr_wd", pr_wd, 32'hA0A0A0A0);
      @(negedge clk);
      checkOutput("rst retry dones", {30'b0, m1_done, m0_done}, 32'h1);
      checkOutput("rst retry m0_rd", m0_rd, 32'hA5A57F04);
      clearInputs();
      @(negedge clk);
      checkOutput("rst final dones", {30'b0, m1_done, m0_done}, 32'h0);
      checkOutput("rst final pr_we", {31'b0, pr_we}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule

// File: doc/dev_bus_arbiter.md
# dev_bus_arbiter

Two-master arbiter and sequencer in front of the CPU-to-device bridge. It shares the single device bus between the CPU data port (master 0) and a secondary bus master such as a loader or DMA engine (master 1). It grants the bus by round-robin and runs each access as a registered three-cycle transaction. Bridge-side outputs drive the bridge's processor-side address, write-enable, write-data and read-data signals directly.

## Interface
- AW, 32, address width
- DW, 32, data width

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  master request; held high with its command stable until that master's done
- m0_addr / m1_addr  in  AW  access address
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_wd / m1_wd  in  DW  write data
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_rd / m1_rd  out  DW  read data, valid while done is high and held until the next completion to that master
- pr_addr  out  AW  address to bridge
- pr_we  out  1  write enable to bridge
- pr_wd  out  DW  write data to bridge
- pr_rd  in  DW  combinational read data from bridge

## Operation
- FSM states:
  - IDLE: if any req is high, pick the owner, latch the owner's addr/we/wd into the bus registers, go to XFER; otherwise stay.
  - XFER: bus registers drive the bridge for exactly one cycle; at the closing edge capture pr_rd into the owner's rd register, set the owner's done, clear the bus registers, go to RESP.
  - RESP: done high for this cycle only; every req is ignored; go to IDLE.
- Arbitration:
  - Only m0_req high → grant 0. Only m1_req high → grant 1.
  - Both high → grant the master that is not `last`. `last` updates to the winner on each grant.
  - Reset value of `last` is 1, so master 0 wins the first tie.
- Write transactions also capture pr_rd into rd. Masters ignore rd on writes.
- The arbiter does no address decode and no device-hit check. The bridge gates its device write enables itself. Out-of-window accesses complete normally with the rd value the bridge returns (0).
- Master rule: drop or change req only on the clock edge that ends the done cycle. A request still high in the IDLE cycle after RESP is treated as a new transaction.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, last = 1
  - pr_addr = 0, pr_we = 0, pr_wd = 0
  - m0_done = m1_done = 0, m0_rd = m1_rd = 0
- Request seen high in IDLE at edge k:
  - pr_* valid during cycle k+1 (all registered, no combinational req→pr path)
  - done high during cycle k+2
  - Next grant is sampled at edge k+3
  - Peak throughput: 1 access per 3 cycles
- pr_we is high for exactly one cycle per write transaction and 0 at all other times. pr_addr and pr_wd are 0 outside XFER.
- Both reqs held continuously: grants alternate 0,1,0,1 with one completion every 3 cycles. Neither master waits more than one transaction.
- Reset asserted during XFER: pr_we falls immediately and no done is issued. The interrupted master re-arbitrates after reset is released.
- A req that rises during XFER or RESP is not lost. It is sampled in the next IDLE cycle.

## Structure
- Shared package holds:
  - FSM state encodings S_IDLE, S_XFER, S_RESP (2-bit)
  - Device window constants DEV0_BASE 0x7F00, DEV0_TOP 0x7F0B, DEV1_BASE 0x7F10, DEV1_TOP 0x7F1B, for bench checks and future decode
- One sub-module: rr_arb2, a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_id.
- The FSM, bus registers and per-master rd/done registers live in dev_bus_arbiter.

## Test plan
- M0 alone writes 0x1234_5678 to 0x7F04 → pr_we=1 for exactly one cycle with pr_addr=0x7F04, pr_wd=0x12345678 → m0_done pulses 2 cycles after grant; m1_done stays 0.
- M1 alone reads 0x7F14 with the bridge model returning 0xDEAD_BEEF → pr_we=0 → m1_rd=0xDEADBEEF with m1_done; m1_rd holds afterwards.
- Both reqs held first from reset, for 4 transactions → order 0,1,0,1; dones spaced exactly 3 cycles apart.
- M0 continuous, M1 raises req mid-XFER → M1 is granted at the next IDLE (last was 0); no done is duplicated or dropped.
- Reset pulse asserted during XFER of a write → pr_we drops in the same cycle, no done pulse, all outputs at reset values; after release the pending req completes normally.
- Read of unmapped 0x0000_3000 with the bridge returning 0 → completes in 3 cycles with rd=0 and pr_we never high.
